// File: rtl/interrupt_pkg.sv
// ============================================================================
// Module      : interrupt_pkg
// Description : Shared types and constants for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package interrupt_pkg;

    localparam int N_IRQ_MAX      = 32;
    localparam int IRQ_IDX_W      = 5;
    localparam int MCAUSE_INT_BIT = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRE  = 2'd1,
        SERVE = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Interrupt flag in the MSB, line index in the low bits.
    function automatic logic [31:0] make_mcause(input logic [IRQ_IDX_W-1:0] idx);
        logic [31:0] v_cause;
        v_cause                  = '0;
        v_cause[MCAUSE_INT_BIT]  = 1'b1;
        v_cause[IRQ_IDX_W-1:0]   = idx;
        return v_cause;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set pending bit at or
//               above rr_ptr, wrapping from N_IRQ-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import interrupt_pkg::*;
#(
    parameter int N_IRQ = 16
) (
    input  logic [N_IRQ-1:0]     pending,
    input  logic [IRQ_IDX_W-1:0] rr_ptr,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] idx
);

    // One spare bit so rr_ptr + offset cannot overflow before the wrap.
    localparam int c_pos_w = IRQ_IDX_W + 1;

    logic [c_pos_w-1:0] w_pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_pos = {1'b0, rr_ptr} + c_pos_w'(i);
            if (w_pos >= c_pos_w'(N_IRQ)) begin
                w_pos = w_pos - c_pos_w'(N_IRQ);
            end
            if (!valid && (|(pending & (N_IRQ'(1) << w_pos)))) begin
                valid = 1'b1;
                idx   = w_pos[IRQ_IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Masks device requests, picks one by round-robin, pulses the
//               core's interrupt-take, then waits for mret and acks the device.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int N_IRQ = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_IRQ-1:0]     int_req_i,
    input  logic [N_IRQ_MAX-1:0] mie_i,
    input  logic                 stall_i,
    input  logic                 mret_i,
    output logic                 int_o,
    output logic [31:0]          mcause_o,
    output logic                 busy_o,
    output logic [N_IRQ-1:0]     int_ack_o
);

    localparam logic [IRQ_IDX_W-1:0] c_last_idx = IRQ_IDX_W'(N_IRQ - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IRQ_IDX_W-1:0]   r_rr_ptr;
    logic [IRQ_IDX_W-1:0]   r_idx;
    logic                   r_int;
    logic [31:0]            r_mcause;
    logic                   r_busy;
    logic [N_IRQ-1:0]       r_ack;

    logic [N_IRQ-1:0]       w_pending;
    logic                   w_arb_valid;
    logic [IRQ_IDX_W-1:0]   w_arb_idx;
    logic [IRQ_IDX_W-1:0]   w_ptr_nxt;
    logic                   w_grant;
    logic                   w_enter_ack;

    assign w_pending = int_req_i & mie_i[N_IRQ-1:0];

    // Mask bits above the implemented lines carry no meaning here.
    generate
        if (N_IRQ < N_IRQ_MAX) begin : g_mie_unused
            logic w_unused_mie;
            assign w_unused_mie = ^mie_i[N_IRQ_MAX-1:N_IRQ];
        end
    endgenerate

    rr_arbiter #(
        .N_IRQ (N_IRQ)
    ) u_rr_arbiter (
        .pending (w_pending),
        .rr_ptr  (r_rr_ptr),
        .valid   (w_arb_valid),
        .idx     (w_arb_idx)
    );

    assign w_ptr_nxt = (w_arb_idx == c_last_idx) ? '0 : (w_arb_idx + IRQ_IDX_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_enter_ack = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid && !stall_i) begin
                    w_state_nxt = FIRE;
                    w_grant     = 1'b1;
                end
            end
            FIRE: begin
                w_state_nxt = SERVE;
            end
            SERVE: begin
                if (mret_i) begin
                    w_state_nxt = ACK;
                    w_enter_ack = 1'b1;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are computed one state ahead so they register in step with r_state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_int    <= 1'b0;
            r_mcause <= '0;
            r_busy   <= 1'b0;
            r_ack    <= '0;
        end else begin
            r_int  <= w_grant;
            r_busy <= (w_state_nxt == FIRE) || (w_state_nxt == SERVE);
            r_ack  <= w_enter_ack ? (N_IRQ'(1) << r_idx) : '0;
            if (w_grant) begin
                r_idx    <= w_arb_idx;
                r_mcause <= make_mcause(w_arb_idx);
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign int_o     = r_int;
    assign mcause_o  = r_mcause;
    assign busy_o    = r_busy;
    assign int_ack_o = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Self-checking bench for interrupt_controller with a
//               transaction-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  int_req_i;
    logic [31:0]   mie_i;
    logic          stall_i;
    logic          mret_i;
    logic          int_o;
    logic [31:0]   mcause_o;
    logic          busy_o;
    logic [N-1:0]  int_ack_o;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    interrupt_controller #(
        .N_IRQ (N)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .int_req_i (int_req_i),
        .mie_i     (mie_i),
        .stall_i   (stall_i),
        .mret_i    (mret_i),
        .int_o     (int_o),
        .mcause_o  (mcause_o),
        .busy_o    (busy_o),
        .int_ack_o (int_ack_o)
    );

    // Winner = first enabled request scanning upward from ptr, modulo N.
    function automatic int model_winner(input logic [N-1:0] req, input logic [31:0] mie, input int ptr);
        logic [N-1:0] p;
        p = req & mie[N-1:0];
        for (int i = 0; i < N; i++) begin
            if (p[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_cause(input int k);
        return 32'h8000_0000 + 32'(k);
    endfunction

    function automatic logic [N-1:0] model_ack(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; int_req_i = '0; mie_i = '0; stall_i = 1'b0; mret_i = 1'b0;
        #3;
        checks++;
        if (int_o !== 1'b0 || busy_o !== 1'b0 || mcause_o !== 32'h0 || int_ack_o !== '0) begin
            errors++;
            $display("FAIL reset int=%0b busy=%0b mcause=%h ack=%h required all zero", int_o, busy_o, mcause_o, int_ack_o);
        end
        apply_reset();
        tick();
        checks++;
        if (int_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req int=%0b busy=%0b required 0 0", int_o, busy_o);
        end
    endtask

    task automatic test_basic();
        int_req_i = 16'h0004; mie_i = 32'h0000_0004; stall_i = 1'b0;
        tick();
        checks++;
        if (int_o !== 1'b1 || mcause_o !== 32'h8000_0002 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_fire int=%0b mcause=%h busy=%0b required 1 80000002 1", int_o, mcause_o, busy_o);
        end
        m_ptr = 3;
        for (int c = 0; c < 3; c++) begin
            int_req_i = N'($urandom); mie_i = $urandom;
            tick();
            checks++;
            if (int_o !== 1'b0 || busy_o !== 1'b1 || int_ack_o !== '0 || mcause_o !== 32'h8000_0002) begin
                errors++;
                $display("FAIL basic_serve int=%0b busy=%0b ack=%h mcause=%h required 0 1 0 80000002", int_o, busy_o, int_ack_o, mcause_o);
            end
        end
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0; int_req_i = '0;
        checks++;
        if (int_ack_o !== 16'h0004 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack ack=%h busy=%0b required 0004 0", int_ack_o, busy_o);
        end
        tick();
        checks++;
        if (int_ack_o !== '0 || mcause_o !== 32'h8000_0002) begin
            errors++;
            $display("FAIL basic_idle ack=%h mcause=%h required 0000 80000002", int_ack_o, mcause_o);
        end
    endtask

    task automatic test_masked();
        int_req_i = 16'h0004; mie_i = 32'h0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (int_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL masked_cycle%0d int=%0b busy=%0b required 0 0", c, int_o, busy_o);
            end
        end
        mie_i = 32'h0000_0004;
        tick();
        checks++;
        if (int_o !== 1'b1 || mcause_o !== model_cause(model_winner(int_req_i, mie_i, m_ptr))) begin
            errors++;
            $display("FAIL unmask_fire int=%0b mcause=%h required 1 80000002", int_o, mcause_o);
        end
        m_ptr = 3;
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0; int_req_i = '0;
        checks++;
        if (int_ack_o !== 16'h0004) begin
            errors++;
            $display("FAIL unmask_ack ack=%h required 0004", int_ack_o);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_k;
        int_req_i = 16'h0005; mie_i = 32'h0000_FFFF; stall_i = 1'b0; mret_i = 1'b0;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            exp_k = model_winner(int_req_i, mie_i, m_ptr);
            tick();
            checks++;
            if (int_o !== 1'b1 || mcause_o !== model_cause(exp_k)) begin
                errors++;
                $display("FAIL rr_round%0d int=%0b mcause=%h required 1 %h", r, int_o, mcause_o, model_cause(exp_k));
            end
            m_ptr = (exp_k + 1) % N;
            mret_i = 1'b1;
            tick();
            checks++;
            if (int_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL rr_serve%0d int=%0b busy=%0b required 0 1", r, int_o, busy_o);
            end
            tick();
            mret_i = 1'b0;
            checks++;
            if (int_ack_o !== model_ack(exp_k)) begin
                errors++;
                $display("FAIL rr_ack%0d ack=%h required %h", r, int_ack_o, model_ack(exp_k));
            end
            tick();
            checks++;
            if (int_o !== 1'b0 || int_ack_o !== '0) begin
                errors++;
                $display("FAIL rr_gap%0d int=%0b ack=%h required 0 0000", r, int_o, int_ack_o);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_k;
        int_req_i = 16'h8000; mie_i = 32'h0000_FFFF;
        tick();
        checks++;
        if (int_o !== 1'b1 || mcause_o !== 32'h8000_000F) begin
            errors++;
            $display("FAIL wrap_line15 int=%0b mcause=%h required 1 8000000f", int_o, mcause_o);
        end
        m_ptr = 0;
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        checks++;
        if (int_ack_o !== 16'h8000) begin
            errors++;
            $display("FAIL wrap_ack ack=%h required 8000", int_ack_o);
        end
        int_req_i = 16'h8001;
        exp_k = model_winner(int_req_i, mie_i, m_ptr);
        tick();
        tick();
        checks++;
        if (int_o !== 1'b1 || mcause_o !== model_cause(exp_k)) begin
            errors++;
            $display("FAIL wrap_next int=%0b mcause=%h required 1 %h", int_o, mcause_o, model_cause(exp_k));
        end
        m_ptr = (exp_k + 1) % N;
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0; int_req_i = '0;
        tick();
    endtask

    task automatic test_stall();
        int exp_k;
        int_req_i = 16'h0010; mie_i = 32'h0000_FFFF; stall_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (int_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d int=%0b busy=%0b required 0 0", c, int_o, busy_o);
            end
        end
        stall_i = 1'b0;
        exp_k = model_winner(int_req_i, mie_i, m_ptr);
        tick();
        checks++;
        if (int_o !== 1'b1 || mcause_o !== model_cause(exp_k)) begin
            errors++;
            $display("FAIL stall_release int=%0b mcause=%h required 1 %h", int_o, mcause_o, model_cause(exp_k));
        end
        m_ptr = (exp_k + 1) % N;
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0; int_req_i = '0;
        tick();
    endtask

    task automatic test_reset_serve();
        int exp_k;
        int_req_i = 16'h0100; mie_i = 32'h0000_FFFF;
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (int_o !== 1'b0 || busy_o !== 1'b0 || mcause_o !== 32'h0 || int_ack_o !== '0) begin
            errors++;
            $display("FAIL async_reset int=%0b busy=%0b mcause=%h ack=%h required all zero", int_o, busy_o, mcause_o, int_ack_o);
        end
        mret_i = 1'b1;
        tick();
        tick();
        mret_i = 1'b0;
        checks++;
        if (int_ack_o !== '0) begin
            errors++;
            $display("FAIL reset_no_ack ack=%h required 0000", int_ack_o);
        end
        rstn = 1'b1;
        m_ptr = 0;
        int_req_i = 16'h0101;
        exp_k = model_winner(int_req_i, mie_i, m_ptr);
        tick();
        checks++;
        if (int_o !== 1'b1 || mcause_o !== model_cause(exp_k)) begin
            errors++;
            $display("FAIL post_reset_fire int=%0b mcause=%h required 1 %h", int_o, mcause_o, model_cause(exp_k));
        end
        m_ptr = (exp_k + 1) % N;
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0; int_req_i = '0;
        tick();
    endtask

    task automatic test_random();
        int exp_k;
        int n_stall;
        int n_serve;
        for (int t = 0; t < 40; t++) begin
            int_req_i = N'($urandom);
            mie_i     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            n_stall   = $urandom_range(0, 3);
            stall_i   = (n_stall != 0);
            for (int c = 0; c < n_stall; c++) begin
                mret_i = 1'($urandom);
                tick();
                checks++;
                if (int_o !== 1'b0 || busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand%0d_stall int=%0b busy=%0b required 0 0", t, int_o, busy_o);
                end
            end
            stall_i = 1'b0; mret_i = 1'b0;
            exp_k = model_winner(int_req_i, mie_i, m_ptr);
            tick();
            if (exp_k < 0) begin
                checks++;
                if (int_o !== 1'b0 || busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand%0d_nopend int=%0b busy=%0b required 0 0", t, int_o, busy_o);
                end
            end else begin
                checks++;
                if (int_o !== 1'b1 || mcause_o !== model_cause(exp_k)) begin
                    errors++;
                    $display("FAIL rand%0d_fire int=%0b mcause=%h required 1 %h", t, int_o, mcause_o, model_cause(exp_k));
                end
                m_ptr = (exp_k + 1) % N;
                n_serve = $urandom_range(1, 4);
                for (int c = 0; c < n_serve; c++) begin
                    int_req_i = N'($urandom); mie_i = $urandom; stall_i = 1'($urandom);
                    tick();
                    checks++;
                    if (int_o !== 1'b0 || busy_o !== 1'b1 || int_ack_o !== '0) begin
                        errors++;
                        $display("FAIL rand%0d_serve int=%0b busy=%0b ack=%h required 0 1 0000", t, int_o, busy_o, int_ack_o);
                    end
                end
                mret_i = 1'b1;
                tick();
                mret_i = 1'b0;
                checks++;
                if (int_ack_o !== model_ack(exp_k) || busy_o !== 1'b0 || mcause_o !== model_cause(exp_k)) begin
                    errors++;
                    $display("FAIL rand%0d_ack ack=%h busy=%0b mcause=%h required %h 0 %h", t, int_ack_o, busy_o, mcause_o, model_ack(exp_k), model_cause(exp_k));
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masked();
        test_round_robin();
        test_wrap();
        test_stall();
        test_reset_serve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences external interrupts into the core's CSR unit.
- Masks device requests with mie and picks one pending line by round-robin.
- Issues a one-cycle interrupt-take pulse with a matching mcause, then holds off further interrupts until the handler executes mret.
- Returns a one-cycle acknowledge to the serviced device.
- Sits between the peripheral interrupt lines and the CSR block / PC-select logic of the core.

Parameters:
- N_IRQ, 16, number of interrupt request lines; legal range 1..32.

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- int_req_i  input  N_IRQ  level-sensitive device requests, synchronous to clk
- mie_i  input  32  interrupt mask from CSR; bit k enables line k; bits >= N_IRQ ignored
- stall_i  input  1  core cannot take an interrupt this cycle (pipeline stall / mid-instruction)
- mret_i  input  1  one-cycle pulse when the core executes mret
- int_o  output  1  one-cycle interrupt-take pulse; drives CSR IC_INT and PC mux to mtvec
- mcause_o  output  32  cause value for CSR mcause_i
- busy_o  output  1  handler in progress; no new interrupt accepted
- int_ack_o  output  N_IRQ  one-hot acknowledge to the serviced device, one cycle

Behaviour:
- Reset (async, rstn=0): state=IDLE, rr_ptr=0, int_o=0, mcause_o=0, busy_o=0, int_ack_o=0, latched index=0. Takes effect immediately, mid-handler included; no ack is issued for an aborted handler.
- pending = int_req_i & mie_i[N_IRQ-1:0], evaluated combinationally in IDLE only.
- Round-robin: the winner is the first set bit of pending scanning upward from rr_ptr, wrapping at N_IRQ-1 -> 0.
- After a grant of index k, rr_ptr <= (k+1) mod N_IRQ. When k = N_IRQ-1, rr_ptr wraps to 0.
- FSM states: IDLE, FIRE, SERVE, ACK. All outputs are registered.
- IDLE:
  - if pending != 0 and !stall_i: latch winner index k, go to FIRE.
  - otherwise stay in IDLE.
  - mret_i is ignored in IDLE.
- FIRE (exactly 1 cycle):
  - int_o=1, busy_o=1.
  - mcause_o = {1'b1, 26'b0, k[4:0]}.
  - unconditionally go to SERVE; stall_i and mret_i are ignored.
- SERVE:
  - busy_o=1, mcause_o held.
  - on mret_i=1: go to ACK.
  - int_req_i and mie_i changes are ignored, including deassertion of line k.
- ACK (exactly 1 cycle):
  - int_ack_o = 1<<k, busy_o=0, mcause_o held.
  - go to IDLE.
- Latency:
  - a request present and unmasked in cycle n, with the FSM in IDLE and stall_i=0, gives int_o=1 in cycle n+1.
  - mret_i in cycle m gives int_ack_o in cycle m+1.
  - minimum gap between two int_o pulses is 4 cycles (FIRE, SERVE, ACK, IDLE).
- mcause_o keeps the last cause after returning to IDLE, until the next FIRE.
- Nesting is not supported: at most one handler is outstanding.
- With all mie bits 0, the block never leaves IDLE.

Decomposition:
- Package interrupt_pkg:
  - state enum (IDLE, FIRE, SERVE, ACK)
  - MCAUSE_INT_BIT = 31
  - IRQ_IDX_W = 5
  - N_IRQ_MAX = 32
- Sub-module rr_arbiter:
  - inputs: pending vector, rr_ptr
  - outputs: valid and winner index
  - purely combinational; the pointer register stays in interrupt_controller.

Test Plan:
- Reset, then int_req_i=0x0004, mie_i=0x0004, stall_i=0 -> int_o pulse one cycle later; mcause_o=0x80000002; busy_o=1 until mret_i; int_ack_o=0x0004 the cycle after mret_i.
- int_req_i=0x0004, mie_i=0x0000 for 20 cycles -> int_o never asserts, busy_o=0. Then set mie_i=0x0004 -> int_o on the next cycle.
- int_req_i=0x0005 held, mie_i=0xFFFF, three full handler rounds -> mcause_o indices 0, 2, 0, confirming round-robin rotation.
- N_IRQ=16, grant line 15, then int_req_i=0x8001 -> next mcause_o=0x80000000, confirming the pointer wraps to 0.
- Request pending with stall_i=1 for 5 cycles -> no int_o. Drop stall_i -> int_o on the next cycle.
- rstn pulled low asynchronously in SERVE -> all outputs 0 immediately, no int_ack_o. After release with the request still high -> new FIRE with rr_ptr=0.
